// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default parameter values and a width helper used to size index/counter fields.
package uart_arb_pkg;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_DATA_W         = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1023;
   localparam int DEF_GAP_CYCLES     = 2;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND      = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_GAP       = 2'd3
   } arb_state_e;

   // Number of bits needed to encode values 0..value-1, never less than one
   // so that degenerate parameters still give a legal vector width.
   function automatic int clog2(input int value);
      int bits;
      bits = 1;
      for (int i = 1; i < 32; i++) begin
         if ((64'(1) << i) < 64'(value)) begin
            bits = i + 1;
         end
      end
      return bits;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin requester selector: starting just after the last winner and
// wrapping around, the first requester with its request bit set is chosen.
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = clog2(DEF_NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic               valid_o,
   output logic [IDX_W-1:0]   index_o
);

   // One extra bit so last+offset never overflows before the wrap is applied.
   localparam int SUM_W = IDX_W + 1;

   logic [SUM_W-1:0] sum;
   logic [IDX_W-1:0] candIdx;

   // Walk the candidates in priority order and keep the first one requesting.
   always_comb begin
      valid_o = 1'b0;
      index_o = '0;
      sum     = '0;
      candIdx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = {1'b0, last_i} + SUM_W'(k);
         if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
         end
         candIdx = sum[IDX_W-1:0];
         if (!valid_o && req_i[candIdx]) begin
            valid_o = 1'b1;
            index_o = candIdx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates several byte producers onto one UART transmitter. A granted byte
// is presented on TDATA, announced with a NEWD pulse, and the frame ends on a
// DONETX rising edge or a timeout, followed by an idle guard gap.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   localparam int IDX_W         = clog2(NUM_REQ)
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NUM_REQ-1:0]        REQ,
   input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
   output logic [NUM_REQ-1:0]        GNT,
   output logic [DATA_W-1:0]         TDATA,
   output logic                      NEWD,
   input  logic                      DONETX,
   output logic [IDX_W-1:0]          GNT_ID,
   output logic                      BUSY,
   output logic                      TO_ERR
);

   localparam int TO_W  = clog2(TIMEOUT_CYCLES + 1);
   localparam int GAP_W = clog2(GAP_CYCLES + 1);

   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

   arb_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [DATA_W-1:0]   tdata_q, tdata_d;
   logic                newd_q, newd_d;
   logic [IDX_W-1:0]    gntId_q, gntId_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic                toErr_q, toErr_d;
   logic [TO_W-1:0]     toCnt_q, toCnt_d;
   logic [GAP_W-1:0]    gapCnt_q, gapCnt_d;
   logic                doneHist_q;

   logic                pickValid;
   logic [IDX_W-1:0]    pickIdx;
   logic                doneRise;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i   (REQ),
      .last_i  (last_q),
      .valid_o (pickValid),
      .index_o (pickIdx)
   );

   // Only a low-to-high transition counts, so a level held high completes one frame at most.
   assign doneRise = DONETX & ~doneHist_q;

   assign GNT    = gnt_q;
   assign TDATA  = tdata_q;
   assign NEWD   = newd_q;
   assign GNT_ID = gntId_q;
   assign TO_ERR = toErr_q;
   assign BUSY   = (state_q != ST_IDLE);

   // State and output registers; reset drops any frame in flight without flagging an error.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         tdata_q    <= '0;
         newd_q     <= 1'b0;
         gntId_q    <= '0;
         last_q     <= LAST_RST;
         toErr_q    <= 1'b0;
         toCnt_q    <= '0;
         gapCnt_q   <= '0;
         doneHist_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         tdata_q    <= tdata_d;
         newd_q     <= newd_d;
         gntId_q    <= gntId_d;
         last_q     <= last_d;
         toErr_q    <= toErr_d;
         toCnt_q    <= toCnt_d;
         gapCnt_q   <= gapCnt_d;
         doneHist_q <= DONETX;
      end
   end

   // Next-state and next-output logic; pulses default low and data fields hold.
   always_comb begin
      state_d  = state_q;
      gnt_d    = '0;
      tdata_d  = tdata_q;
      newd_d   = 1'b0;
      gntId_d  = gntId_q;
      last_d   = last_q;
      toErr_d  = 1'b0;
      toCnt_d  = toCnt_q;
      gapCnt_d = gapCnt_q;

      case (state_q)
         ST_IDLE: begin
            if (pickValid) begin
               gnt_d   = NUM_REQ'(1) << pickIdx;
               tdata_d = REQ_DATA[pickIdx*DATA_W +: DATA_W];
               gntId_d = pickIdx;
               last_d  = pickIdx;
               state_d = ST_SEND;
            end
         end

         ST_SEND: begin
            newd_d  = 1'b1;
            toCnt_d = '0;
            state_d = ST_WAIT_DONE;
         end

         ST_WAIT_DONE: begin
            if (doneRise) begin
               gapCnt_d = '0;
               state_d  = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end else if (toCnt_q == TO_LAST) begin
               toErr_d  = 1'b1;
               gapCnt_d = '0;
               state_d  = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end else begin
               toCnt_d = toCnt_q + TO_W'(1);
            end
         end

         ST_GAP: begin
            if (gapCnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gapCnt_d = gapCnt_q + GAP_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus predicts each frame from the
// round-robin rule and queues it; a monitor checks every grant/frame and a
// transmitter model answers NEWD with DONETX after a scripted delay.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ        = 4;
   localparam int DATA_W         = 8;
   localparam int TIMEOUT_CYCLES = 1023;
   localparam int GAP_CYCLES     = 2;

   typedef struct {
      int          id;
      logic [7:0]  data;
      int          delay;
      int          hold;
      bit          spurious;
   } frame_t;

   logic                      CLK;
   logic                      RST;
   logic [NUM_REQ-1:0]        REQ;
   logic [NUM_REQ*DATA_W-1:0] REQ_DATA;
   logic [NUM_REQ-1:0]        GNT;
   logic [DATA_W-1:0]         TDATA;
   logic                      NEWD;
   logic                      DONETX;
   logic [1:0]                GNT_ID;
   logic                      BUSY;
   logic                      TO_ERR;

   int     checks;
   int     failures;
   bit     inReset;
   bit     frameActive;
   bit     txActive;
   int     modelLast;
   frame_t expQ[$];
   frame_t txQ[$];

   uart_tx_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .DATA_W         (DATA_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .GAP_CYCLES     (GAP_CYCLES)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .REQ      (REQ),
      .REQ_DATA (REQ_DATA),
      .GNT      (GNT),
      .TDATA    (TDATA),
      .NEWD     (NEWD),
      .DONETX   (DONETX),
      .GNT_ID   (GNT_ID),
      .BUSY     (BUSY),
      .TO_ERR   (TO_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Round-robin reference: search upward from the previous winner, wrapping.
   function automatic int rrWinner(input logic [NUM_REQ-1:0] mask);
      for (int off = 1; off <= NUM_REQ; off++) begin
         int c;
         c = (modelLast + off) % NUM_REQ;
         if (mask[c]) return c;
      end
      return -1;
   endfunction

   // Queue the predicted frame, raise the request and wait for its grant.
   task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input int delay, input int hold,
                                input bit spurious, input bit keepMask, input logic [NUM_REQ-1:0] decoy);
      frame_t f;
      int     n;
      f.id       = rrWinner(mask);
      f.data     = REQ_DATA[f.id*DATA_W +: DATA_W];
      f.delay    = delay;
      f.hold     = hold;
      f.spurious = spurious;
      modelLast  = f.id;
      expQ.push_back(f);
      txQ.push_back(f);
      REQ = mask;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (GNT == '0 && n < 3000);
      if (GNT == '0) checkOutput("grant_wait_expired", 0, 1);
      if (!keepMask) begin
         REQ      = decoy;
         REQ_DATA = {$urandom};
         @(negedge CLK);
         REQ = '0;
      end
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((expQ.size() != 0 || frameActive || BUSY) && n < 5000) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 5000) checkOutput("idle_wait_expired", 0, 1);
   endtask

   task automatic pulseReset();
      inReset = 1'b1;
      RST     = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // Monitor: every grant pops one predicted frame and follows it to IDLE.
   initial begin
      frame_t f;
      int toK, toCnt, idleK, extra, expTo, tEnd;
      frameActive = 1'b0;
      forever begin
         @(negedge CLK);
         if (!inReset && GNT != '0) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_gnt", 32'(GNT), 0);
            end else begin
               frameActive = 1'b1;
               f = expQ.pop_front();
               checkOutput("gnt_onehot", 32'(GNT), 32'(1) << f.id);
               checkOutput("gnt_id", 32'(GNT_ID), f.id);
               checkOutput("tdata_at_gnt", 32'(TDATA), 32'(f.data));
               checkOutput("newd_with_gnt", 32'(NEWD), 0);
               @(negedge CLK);
               if (!inReset) begin
                  checkOutput("newd_pulse", 32'(NEWD), 1);
                  checkOutput("gnt_cleared", 32'(GNT), 0);
                  checkOutput("tdata_at_newd", 32'(TDATA), 32'(f.data));
                  toK = 0; toCnt = 0; idleK = 0; extra = 0;
                  for (int k = 1; k <= TIMEOUT_CYCLES + GAP_CYCLES + 50; k++) begin
                     @(negedge CLK);
                     if (inReset) break;
                     if (TO_ERR) begin
                        toCnt++;
                        if (toK == 0) toK = k;
                     end
                     if (NEWD || GNT != '0) extra++;
                     if (!BUSY) begin
                        idleK = k;
                        break;
                     end
                  end
                  if (!inReset) begin
                     expTo = (f.delay == 0) ? TIMEOUT_CYCLES : 0;
                     tEnd  = (f.delay == 0) ? TIMEOUT_CYCLES : f.delay;
                     checkOutput("to_err_time", toK, expTo);
                     checkOutput("to_err_width", toCnt, (expTo != 0) ? 1 : 0);
                     checkOutput("idle_time", idleK, tEnd + GAP_CYCLES);
                     checkOutput("no_extra_pulses", extra, 0);
                     checkOutput("tdata_hold", 32'(TDATA), 32'(f.data));
                  end
               end
               frameActive = 1'b0;
            end
         end
      end
   end

   // Transmitter model: after NEWD, raise DONETX at the scripted cycle (0 = never).
   initial begin
      frame_t t;
      DONETX   = 1'b0;
      txActive = 1'b0;
      forever begin
         @(negedge CLK);
         if (NEWD === 1'b1 && !inReset) begin
            if (txQ.size() == 0) begin
               checkOutput("tx_unexpected_newd", 1, 0);
            end else begin
               t = txQ.pop_front();
               if (t.delay > 0) begin
                  txActive = 1'b1;
                  repeat (t.delay - 1) @(negedge CLK);
                  DONETX = 1'b1;
                  repeat (t.hold) @(negedge CLK);
                  DONETX = 1'b0;
                  if (t.spurious) begin
                     repeat (5) @(negedge CLK);
                     DONETX = 1'b1;
                     @(negedge CLK);
                     DONETX = 1'b0;
                  end
                  txActive = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #600000;
      failures++;
      $display("[TB] FAIL watchdog: actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int busyCnt, toSeen, rndTimeouts, delay;
      checks    = 0;
      failures  = 0;
      inReset   = 1'b1;
      RST       = 1'b1;
      REQ       = '0;
      REQ_DATA  = '0;
      modelLast = NUM_REQ - 1;

      repeat (3) @(negedge CLK);
      checkOutput("rst_gnt", 32'(GNT), 0);
      checkOutput("rst_newd", 32'(NEWD), 0);
      checkOutput("rst_to_err", 32'(TO_ERR), 0);
      checkOutput("rst_tdata", 32'(TDATA), 0);
      checkOutput("rst_gnt_id", 32'(GNT_ID), 0);
      checkOutput("rst_busy", 32'(BUSY), 0);
      RST = 1'b0;
      @(negedge CLK);
      inReset = 1'b0;

      $display("[TB] single request with slow transmitter, REQ[2] pulsed while busy");
      REQ_DATA = 32'h0000_00A5;
      applyStimulus(4'b0001, 500, 2, 1'b0, 1'b0, 4'b0100);
      waitIdle();

      $display("[TB] contention with all requests held");
      pulseReset();
      @(negedge CLK);
      inReset   = 1'b0;
      modelLast = NUM_REQ - 1;
      REQ_DATA  = 32'h4433_2211;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b1111, $urandom_range(5, 30), $urandom_range(1, 3), 1'b0, 1'b1, '0);
      end
      REQ = '0;
      waitIdle();

      $display("[TB] timeout, recovery and done-versus-timeout boundary");
      REQ_DATA = {$urandom};
      applyStimulus(4'b0010, 0, 1, 1'b0, 1'b0, '0);
      applyStimulus(4'b0001, 12, 2, 1'b0, 1'b0, '0);
      applyStimulus(4'b1000, TIMEOUT_CYCLES, 1, 1'b0, 1'b0, '0);
      applyStimulus(4'b0100, TIMEOUT_CYCLES - 1, 1, 1'b0, 1'b0, '0);
      waitIdle();

      $display("[TB] DONETX held high and a stray DONETX pulse while idle");
      REQ_DATA = {$urandom};
      applyStimulus(4'b0010, 8, 20, 1'b1, 1'b0, '0);
      waitIdle();
      busyCnt = 0;
      repeat (40) begin
         @(negedge CLK);
         if (BUSY) busyCnt++;
      end
      checkOutput("busy_after_stray_done", busyCnt, 0);

      $display("[TB] reset during WAIT_DONE");
      REQ_DATA = {$urandom};
      applyStimulus(4'b0001, 0, 1, 1'b0, 1'b0, '0);
      repeat (10) @(negedge CLK);
      pulseReset();
      checkOutput("midrst_gnt", 32'(GNT), 0);
      checkOutput("midrst_newd", 32'(NEWD), 0);
      checkOutput("midrst_tdata", 32'(TDATA), 0);
      checkOutput("midrst_gnt_id", 32'(GNT_ID), 0);
      checkOutput("midrst_busy", 32'(BUSY), 0);
      toSeen = 0;
      repeat (20) begin
         @(negedge CLK);
         if (TO_ERR) toSeen++;
      end
      checkOutput("midrst_no_to_err", toSeen, 0);
      inReset   = 1'b0;
      modelLast = NUM_REQ - 1;
      REQ_DATA  = {$urandom};
      applyStimulus(4'b0100, 9, 2, 1'b0, 1'b0, '0);
      waitIdle();

      $display("[TB] randomized traffic");
      rndTimeouts = 0;
      for (int i = 0; i < 40; i++) begin
         REQ_DATA = {$urandom};
         if ($urandom_range(0, 7) == 0 && rndTimeouts < 3) begin
            delay = 0;
            rndTimeouts++;
         end else begin
            delay = $urandom_range(1, 40);
         end
         applyStimulus(4'($urandom_range(1, 15)), delay, $urandom_range(1, 3), 1'b0, 1'b0,
                       4'($urandom_range(0, 15)));
      end
      waitIdle();
      repeat (5) @(negedge CLK);
      checkOutput("scoreboard_drained", expQ.size() + txQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter DATA_W, 8, byte width presented to transmitter.
REQ-003 Parameter TIMEOUT_CYCLES, 1023, max CLK cycles from NEWD to DONETX rising edge before abort.
REQ-004 Parameter GAP_CYCLES, 2, idle guard cycles between frames (0 allowed).
REQ-005 CLK  in  1  single clock; all logic on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 REQ  in  NUM_REQ  per-requester send request, level, held until granted.
REQ-008 REQ_DATA  in  NUM_REQ*DATA_W  requester i byte at slice [i*DATA_W +: DATA_W].
REQ-009 GNT  out  NUM_REQ  one-hot, one-cycle pulse: requester's byte accepted.
REQ-010 TDATA  out  DATA_W  byte to transmitter, held stable from grant until return to IDLE.
REQ-011 NEWD  out  1  one-cycle start pulse to transmitter.
REQ-012 DONETX  in  1  transmitter completion; acted on at rising edge only.
REQ-013 GNT_ID  out  clog2(NUM_REQ)  index of current/last granted requester.
REQ-014 BUSY  out  1  high whenever state is not IDLE.
REQ-015 TO_ERR  out  1  one-cycle pulse when a frame times out.

Function
REQ-016 All outputs are registered, except BUSY, which is decoded from the state register.
REQ-017 FSM states are IDLE, SEND, WAIT_DONE and GAP.
REQ-018 IDLE: if any REQ bit is high at edge t, the arbiter selects a winner, and at t+1 it shall assert GNT[winner], load TDATA from the winner's slice, set GNT_ID, and enter SEND.
REQ-019 Winner selection is round-robin: scan starts at LAST+1 mod NUM_REQ, and the first set REQ bit wins; LAST takes the winner index.
REQ-020 SEND: NEWD is high for exactly one cycle (t+2 relative to the REQ sample), then the FSM enters WAIT_DONE with the timeout counter cleared.
REQ-021 WAIT_DONE: the counter increments each cycle; a DONETX rising edge moves the FSM to GAP.
REQ-022 WAIT_DONE: counter == TIMEOUT_CYCLES-1 with no DONETX edge pulses TO_ERR for one cycle and moves the FSM to GAP.
REQ-023 If the DONETX edge and the timeout occur in the same cycle, DONETX wins and TO_ERR stays low.
REQ-024 GAP: the FSM stays GAP_CYCLES cycles, then enters IDLE; GAP_CYCLES=0 means direct transition to IDLE.
REQ-025 DONETX edges outside WAIT_DONE are ignored.
REQ-026 Edge detection uses a registered copy of DONETX, so a DONETX level held high never re-triggers.
REQ-027 REQ changes outside IDLE have no effect; a REQ dropped before grant is withdrawn with no grant.
REQ-028 GNT and NEWD never assert in the same cycle, and at most one GNT bit is high per cycle.
REQ-029 Fairness: with all requests held, each requester is granted once per NUM_REQ frames.

Reset
REQ-030 While RST is high at an edge: state=IDLE, GNT=0, NEWD=0, TO_ERR=0, TDATA=0, GNT_ID=0, counters=0, DONETX history=0, LAST=NUM_REQ-1 (requester 0 has first priority).
REQ-031 RST asserted mid-frame aborts the frame without TO_ERR; the requester is not re-granted unless it re-requests.

Structure
REQ-032 Shared package uart_arb_pkg holds the FSM state enum, default parameter constants and the clog2 helper.
REQ-033 The round-robin selector is a combinational sub-module, uart_rr_pick (inputs REQ and LAST; outputs valid and index).
REQ-034 The timeout counter is wide enough for TIMEOUT_CYCLES, and comparisons are unsigned.

Verification
REQ-035 Single request: REQ=4'b0001, byte 8'hA5, with the transmitter model giving DONETX after 500 cycles -> GNT=0001 at t+1, TDATA=A5, NEWD at t+2, TO_ERR=0, IDLE after 2 gap cycles.
REQ-036 Contention: REQ=4'b1111 held, bytes 11/22/33/44 -> NEWD order 11,22,33,44,11; GNT_ID sequence 0,1,2,3,0.
REQ-037 Timeout: no DONETX -> TO_ERR pulse exactly 1023 cycles after NEWD, then next request served normally.
REQ-038 DONETX held high 20 cycles, plus spurious DONETX pulse in IDLE -> single frame completion, no extra grant.
REQ-039 RST for 1 cycle during WAIT_DONE -> all outputs reset next cycle, no TO_ERR; a subsequent REQ=4'b0100 wins first after requester 0/1 idle.
REQ-040 Withdraw: REQ[2] pulsed high only while BUSY -> never granted.
